shared_adder_sched: RTL and testbench
=====================================

SHARED_ADDER_SCHED -- requirements
Module: shared_adder_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the adder (power of two, 2..8).
REQ-002 Parameter W, default 4, operand and sum width in bits.
REQ-003 Parameter CW, default 8, width of the completed-transaction counter.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  NREQ  per-requester request valid.
REQ-007 req_a  input  NREQ*W  operand A; requester i occupies bits [i*W +: W].
REQ-008 req_b  input  NREQ*W  operand B; same packing as req_a.
REQ-009 req_ready  output  NREQ  one-hot grant/accept strobe; at most one bit high per cycle.
REQ-010 rsp_valid  output  1  result valid.
REQ-011 rsp_ready  input  1  downstream accepts result.
REQ-012 rsp_id  output  clog2(NREQ)  index of the requester that owns the result.
REQ-013 rsp_sum  output  W  (a+b) mod 2^W.
REQ-014 rsp_carry  output  1  bit W of a+b.
REQ-015 txn_count  output  CW  number of completed response handshakes, wrapping modulo 2^CW.

Function
REQ-016 The block SHALL implement a three-state FSM: IDLE, ADD, RESP.
REQ-017 In IDLE with any req_valid high, the block SHALL drive req_ready high for exactly one requester, the round-robin winner: the first set req_valid bit at or after index ptr, scanning upward with wrap from NREQ-1 to 0.
REQ-018 req_ready SHALL be combinational from state, ptr and req_valid, and SHALL be all-zero in ADD and RESP.
REQ-019 On a cycle with req_valid[i] and req_ready[i] both high, the block SHALL latch req_a[i], req_b[i] and i, and transition IDLE->ADD.
REQ-020 In ADD the block SHALL register the W+1-bit sum of the latched operands into rsp_sum/rsp_carry, drive rsp_id with the latched index, and transition ADD->RESP unconditionally.
REQ-021 In RESP rsp_valid SHALL be high; rsp_id, rsp_sum and rsp_carry SHALL be held stable until the handshake.
REQ-022 On rsp_valid and rsp_ready both high, the block SHALL transition RESP->IDLE, set ptr to (rsp_id+1) mod NREQ, and increment txn_count by one with wrap.
REQ-023 Minimum latency SHALL be: request accept in cycle N, rsp_valid high in cycle N+2; minimum issue interval 3 cycles.
REQ-024 In IDLE with no req_valid, the block SHALL remain in IDLE with ptr unchanged.
REQ-025 req_valid changes while in ADD or RESP SHALL have no effect; requesters hold valid until their ready strobe.
REQ-026 rsp_valid SHALL be low in IDLE and ADD.

Reset
REQ-027 While reset is high, the block SHALL hold state IDLE, ptr=0, txn_count=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, req_ready=0.
REQ-028 Reset asserted in ADD or RESP SHALL abort the transaction; the pending result is discarded and txn_count is not incremented.
REQ-029 After reset deassertion, the first grant SHALL go to the lowest-indexed valid requester.

Structure
REQ-030 A shared package shared_adder_pkg SHALL hold the FSM state type (IDLE, ADD, RESP) and the default NREQ, W and CW constants.
REQ-031 Round-robin winner selection SHALL be a sub-module rr_arbiter (inputs: valid vector, ptr; output: one-hot grant, encoded index).
REQ-032 The adder SHALL be a single W-bit instance in this block; no per-requester adders.

Verification
REQ-033 Single request: req_valid=0001, a0=4'h7, b0=4'h5 -> req_ready=0001 in same cycle; two cycles later rsp_valid=1, rsp_id=0, rsp_sum=4'hC, rsp_carry=0.
REQ-034 Overflow: requester 2 a=4'hF, b=4'h3 -> rsp_id=2, rsp_sum=4'h2, rsp_carry=1.
REQ-035 Fairness: req_valid=1111 held continuously, rsp_ready=1 -> grants in order 0,1,2,3,0; txn_count=5 after fifth handshake.
REQ-036 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_* stable, req_ready=0000, txn_count unchanged; rsp_ready=1 -> IDLE next cycle.
REQ-037 Reset mid-operation: assert reset in ADD -> all outputs zero immediately; after release with req_valid=1010, first grant to requester 1.
REQ-038 Counter wrap: 256 completed transactions with CW=8 -> txn_count returns to 0.

Source files
------------

// File: rtl/shared_adder_pkg.sv
// Shared types and default sizing for the shared-adder scheduler.
package shared_adder_pkg;

   // Controller phases: wait for a request, add, present the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int DEF_NREQ = 4;   // requesters sharing the adder
   localparam int DEF_W    = 4;   // operand / sum width
   localparam int DEF_CW   = 8;   // completed-transaction counter width

endpackage

// File: rtl/shared_adder_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first valid requester at or above ptr,
// wrapping from NREQ-1 back to 0. Purely combinational.
module rr_arbiter
   import shared_adder_pkg::*;
#(
   parameter int NREQ = DEF_NREQ
) (
   input  logic [NREQ-1:0]         valid_i,
   input  logic [$clog2(NREQ)-1:0] ptr_i,
   output logic [NREQ-1:0]         grant_o,
   output logic [$clog2(NREQ)-1:0] idx_o,
   output logic                    any_o
);

   localparam int IW = $clog2(NREQ);

   logic [IW-1:0] cand;

   // Scan upward from ptr; NREQ is a power of two so IW-bit addition wraps.
   always_comb begin
      // NOTE: every output gets a default before the loop so no latch is inferred.
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      cand    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = ptr_i + IW'(k);
         if (!any_o && valid_i[cand]) begin
            any_o       = 1'b1;
            idx_o       = cand;
            grant_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/shared_adder_sched.sv
// Time-shares one W-bit adder among NREQ requesters. A round-robin winner is
// accepted in IDLE, its operands are summed in ADD, and the result is held in
// RESP until the downstream handshake.
module shared_adder_sched
   import shared_adder_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int W    = DEF_W,
   parameter int CW   = DEF_CW
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*W-1:0]       req_a,
   input  logic [NREQ*W-1:0]       req_b,
   output logic [NREQ-1:0]         req_ready,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [W-1:0]            rsp_sum,
   output logic                    rsp_carry,
   output logic [CW-1:0]           txn_count
);

   localparam int IW = $clog2(NREQ);

   state_e        state_q;
   logic [IW-1:0] ptr_q;
   logic [IW-1:0] op_id_q;
   logic [W-1:0]  op_a_q;
   logic [W-1:0]  op_b_q;

   logic [NREQ-1:0] grant;
   logic [IW-1:0]   grant_idx;
   logic            grant_any;
   logic            accept;
   logic [W:0]      sum_d;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .valid_i (req_valid),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .idx_o   (grant_idx),
      .any_o   (grant_any)
   );

   // Grant only while idle and out of reset; silent in ADD and RESP.
   assign req_ready = (state_q == IDLE && !reset) ? grant : '0;
   assign accept    = (state_q == IDLE) && grant_any;

   // The one shared adder, fed from the latched operands.
   assign sum_d = {1'b0, op_a_q} + {1'b0, op_b_q};

   // Controller and result registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples pre-edge values regardless of statement order.
         state_q   <= IDLE;
         ptr_q     <= '0;
         op_id_q   <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rsp_carry <= 1'b0;
         txn_count <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  op_a_q  <= req_a[grant_idx*W +: W];
                  op_b_q  <= req_b[grant_idx*W +: W];
                  op_id_q <= grant_idx;
                  state_q <= ADD;
               end
            end
            ADD: begin
               rsp_sum   <= sum_d[W-1:0];
               rsp_carry <= sum_d[W];
               rsp_id    <= op_id_q;
               rsp_valid <= 1'b1;
               state_q   <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  ptr_q     <= rsp_id + IW'(1);
                  txn_count <= txn_count + CW'(1);
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shared_adder_sched.sv
// Directed plus randomized bench for shared_adder_sched against a small
// arithmetic reference model (round-robin pointer, counter, a+b).
module tb_shared_adder_sched;

   localparam int NREQ = 4;
   localparam int W    = 4;
   localparam int CW   = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic [NREQ-1:0]  req_valid;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]  req_ready;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [1:0]       rsp_id;
   logic [W-1:0]     rsp_sum;
   logic             rsp_carry;
   logic [CW-1:0]    txn_count;

   int errors = 0;
   int checks = 0;
   int m_ptr   = 0;
   int m_count = 0;

   shared_adder_sched #(.NREQ(NREQ), .W(W), .CW(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_carry (rsp_carry),
      .txn_count (txn_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // First set bit at or after p, wrapping; -1 when nothing is valid.
   function automatic int winner(input logic [3:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [31:0] onehot(input int w);
      return (w < 0) ? 32'd0 : (32'd1 << w);
   endfunction

   task automatic check_resp(input string tag, input int id, input int sum, input int carry);
      check({tag, "_valid"}, rsp_valid, 1);
      check({tag, "_id"}, rsp_id, id);
      check({tag, "_sum"}, rsp_sum, sum);
      check({tag, "_carry"}, rsp_carry, carry);
      check({tag, "_count"}, txn_count, m_count);
      check({tag, "_ready"}, req_ready, 0);
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after the
   // response handshake with the model updated.
   task automatic do_txn(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                         input int stall, input bit scramble, output int w);
      int ea, eb, full;
      req_valid = v;
      req_a     = a;
      req_b     = b;
      rsp_ready = 1'b0;
      #1;
      w = winner(v, m_ptr);
      check("grant", req_ready, onehot(w));
      ea   = int'(a[w*4 +: 4]);
      eb   = int'(b[w*4 +: 4]);
      full = ea + eb;
      @(negedge clk);
      check("add_ready", req_ready, 0);
      check("add_valid", rsp_valid, 0);
      if (scramble) req_valid = 4'($urandom);
      @(negedge clk);
      for (int s = 0; s < stall; s++) begin
         check_resp("stall", w, full % 16, full / 16);
         if (scramble) req_valid = 4'($urandom);
         @(negedge clk);
      end
      check_resp("resp", w, full % 16, full / 16);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      m_ptr   = (w + 1) % NREQ;
      m_count = (m_count + 1) % (1 << CW);
      check("post_valid", rsp_valid, 0);
      check("post_count", txn_count, m_count);
      check("post_idle_grant", req_ready, onehot(winner(req_valid, m_ptr)));
   endtask

   initial begin
      int w;
      int fair_exp [5];
      logic [3:0] v;
      fair_exp = '{0, 1, 2, 3, 0};

      reset     = 1'b1;
      req_valid = 4'hF;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ready", req_ready, 0);
      check("rst_valid", rsp_valid, 0);
      check("rst_id", rsp_id, 0);
      check("rst_sum", rsp_sum, 0);
      check("rst_carry", rsp_carry, 0);
      check("rst_count", txn_count, 0);
      reset = 1'b0;
      m_ptr = 0;
      m_count = 0;

      // Fairness with all requesters held valid.
      for (int i = 0; i < 5; i++) begin
         do_txn(4'hF, 16'($urandom), 16'($urandom), 0, 1'b0, w);
         check("fair_order", w, fair_exp[i]);
      end
      check("fair_count", txn_count, 5);

      // No requests: stays idle, nothing granted.
      req_valid = 4'h0;
      repeat (3) begin
         #1;
         check("idle_ready", req_ready, 0);
         check("idle_valid", rsp_valid, 0);
         @(negedge clk);
      end

      // Single request 7+5 from requester 0.
      do_txn(4'b0001, 16'h0007, 16'h0005, 0, 1'b0, w);
      check("single_id", w, 0);

      // Overflow from requester 2: F+3.
      do_txn(4'b0100, 16'h0F00, 16'h0300, 0, 1'b0, w);
      check("ovf_id", w, 2);

      // Backpressure for 10 cycles with requesters changing underneath.
      do_txn(4'($urandom_range(1, 15)), 16'($urandom), 16'($urandom), 10, 1'b1, w);

      // Reset while in ADD.
      req_valid = 4'b0001;
      req_a     = 16'h0009;
      req_b     = 16'h0009;
      #1;
      check("pre_rst_grant", req_ready, onehot(winner(4'b0001, m_ptr)));
      @(negedge clk);
      reset = 1'b1;
      req_valid = 4'b1010;
      #1;
      check("abort_ready", req_ready, 0);
      check("abort_valid", rsp_valid, 0);
      check("abort_id", rsp_id, 0);
      check("abort_sum", rsp_sum, 0);
      check("abort_carry", rsp_carry, 0);
      check("abort_count", txn_count, 0);
      @(negedge clk);
      reset   = 1'b0;
      m_ptr   = 0;
      m_count = 0;
      do_txn(4'b1010, 16'($urandom), 16'($urandom), 0, 1'b0, w);
      check("post_rst_first", w, 1);

      // 255 more random transactions: 256 since reset, counter wraps to 0.
      for (int i = 0; i < 255; i++) begin
         v = 4'($urandom_range(1, 15));
         do_txn(v, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
                1'($urandom), w);
      end
      check("wrap_count", txn_count, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
